// File: rtl/pipe_opcode_tracker.sv
`default_nettype none
// ============================================================================
// Module   : pipe_opcode_tracker
// Brief    : Tracks opcodes through a 5-stage pipeline with stall/flush control.
// Revision : 1.0
// ============================================================================
module pipe_opcode_tracker #(
    parameter int             OPW       = 7,
    parameter logic [OPW-1:0] BUBBLE    = '0,
    parameter logic [OPW-1:0] LOAD_OP   = OPW'(3),
    parameter int             STALL_MAX = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    input  logic [OPW-1:0] in_opcode,
    output logic           in_ready,
    input  logic           stall,
    input  logic           flush,
    output logic [OPW-1:0] fetch,
    output logic [OPW-1:0] decode,
    output logic [OPW-1:0] exec,
    output logic [OPW-1:0] mem,
    output logic [OPW-1:0] wb,
    output logic [1:0]     pipeline_state,
    output logic           empty,
    output logic [15:0]    retired,
    output logic [15:0]    stall_cycles,
    output logic           stall_err
);

    localparam int             RUNW    = $clog2(STALL_MAX + 1);
    localparam logic [RUNW-1:0] RUN_MAX = RUNW'(STALL_MAX);

    logic [OPW-1:0]  fetch_nx;
    logic [OPW-1:0]  decode_nx;
    logic [OPW-1:0]  exec_nx;
    logic [OPW-1:0]  mem_nx;
    logic [OPW-1:0]  wb_nx;
    logic [1:0]      state_nx;
    logic            empty_nx;
    logic [RUNW-1:0] stall_run;
    logic [RUNW-1:0] stall_run_nx;

    assign in_ready = !stall && !flush;

    always_comb begin
        // Stall defaults: fetch/decode hold, exec takes a bubble, older slots drain.
        fetch_nx  = fetch;
        decode_nx = decode;
        exec_nx   = BUBBLE;
        mem_nx    = exec;
        wb_nx     = mem;
        if (flush) begin
            fetch_nx  = BUBBLE;
            decode_nx = BUBBLE;
        end else if (!stall) begin
            fetch_nx  = in_valid ? in_opcode : BUBBLE;
            decode_nx = fetch;
            exec_nx   = decode;
        end
    end

    always_comb begin
        state_nx = 2'b00;
        if (decode_nx == LOAD_OP) begin
            state_nx = 2'b01;
        end else if (exec_nx == LOAD_OP) begin
            state_nx = 2'b10;
        end else if (mem_nx == LOAD_OP) begin
            state_nx = 2'b11;
        end
        empty_nx = (fetch_nx == BUBBLE) && (decode_nx == BUBBLE) && (exec_nx == BUBBLE)
                && (mem_nx == BUBBLE) && (wb_nx == BUBBLE);
    end

    always_comb begin
        stall_run_nx = '0;
        if (stall) begin
            stall_run_nx = (stall_run == RUN_MAX) ? stall_run : stall_run + RUNW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch          <= BUBBLE;
            decode         <= BUBBLE;
            exec           <= BUBBLE;
            mem            <= BUBBLE;
            wb             <= BUBBLE;
            pipeline_state <= 2'b00;
            empty          <= 1'b1;
            retired        <= '0;
            stall_cycles   <= '0;
            stall_run      <= '0;
            stall_err      <= 1'b0;
        end else begin
            fetch          <= fetch_nx;
            decode         <= decode_nx;
            exec           <= exec_nx;
            mem            <= mem_nx;
            wb             <= wb_nx;
            pipeline_state <= state_nx;
            empty          <= empty_nx;
            stall_run      <= stall_run_nx;
            if ((wb != BUBBLE) && (retired != 16'hFFFF)) begin
                retired <= retired + 16'd1;
            end
            if (stall && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
            if (stall && (stall_run_nx == RUN_MAX)) begin
                stall_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_opcode_tracker.sv
`default_nettype none
// Self-checking bench for pipe_opcode_tracker: directed scenarios plus a
// randomized run compared against a slot-array reference model.
module tb_pipe_opcode_tracker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [6:0]  in_opcode;
    logic        in_ready;
    logic        stall;
    logic        flush;
    logic [6:0]  fetch, decode, exec, mem, wb;
    logic [1:0]  pipeline_state;
    logic        empty;
    logic [15:0] retired;
    logic [15:0] stall_cycles;
    logic        stall_err;

    int checks = 0;
    int errors = 0;

    // Reference model: index 0 = fetch ... 4 = wb.
    logic [6:0]  m_slot [5];
    logic [15:0] m_ret;
    logic [15:0] m_stc;
    int          m_run;
    logic        m_err;

    logic [6:0]  dut_slot [5];
    string       slot_name [5] = '{"fetch", "decode", "exec", "mem", "wb"};

    assign dut_slot[0] = fetch;
    assign dut_slot[1] = decode;
    assign dut_slot[2] = exec;
    assign dut_slot[3] = mem;
    assign dut_slot[4] = wb;

    always #5 clk = ~clk;

    pipe_opcode_tracker dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_opcode      (in_opcode),
        .in_ready       (in_ready),
        .stall          (stall),
        .flush          (flush),
        .fetch          (fetch),
        .decode         (decode),
        .exec           (exec),
        .mem            (mem),
        .wb             (wb),
        .pipeline_state (pipeline_state),
        .empty          (empty),
        .retired        (retired),
        .stall_cycles   (stall_cycles),
        .stall_err      (stall_err)
    );

    function automatic logic [1:0] exp_state();
        if (m_slot[1] == 7'h03) return 2'b01;
        if (m_slot[2] == 7'h03) return 2'b10;
        if (m_slot[3] == 7'h03) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic exp_empty();
        foreach (m_slot[i]) if (m_slot[i] != 7'h00) return 1'b0;
        return 1'b1;
    endfunction

    // Applies the behavioural rules for one clock edge using the inputs present at that edge.
    task automatic model_step();
        logic [6:0] o [5];
        o = m_slot;
        if (!rst_n) begin
            foreach (m_slot[i]) m_slot[i] = 7'h00;
            m_ret = 0; m_stc = 0; m_run = 0; m_err = 1'b0;
        end else begin
            if (o[4] != 7'h00 && m_ret != 16'hFFFF) m_ret++;
            m_slot[4] = o[3];
            m_slot[3] = o[2];
            if (flush) begin
                m_slot[0] = 7'h00; m_slot[1] = 7'h00; m_slot[2] = 7'h00;
            end else if (stall) begin
                m_slot[2] = 7'h00;
            end else begin
                m_slot[2] = o[1];
                m_slot[1] = o[0];
                m_slot[0] = in_valid ? in_opcode : 7'h00;
            end
            if (stall) begin
                if (m_stc != 16'hFFFF) m_stc++;
                m_run = (m_run < 8) ? m_run + 1 : 8;
                if (m_run == 8) m_err = 1'b1;
            end else begin
                m_run = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_opcode = 7'h00; stall = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b1; flush = 1'b1; in_valid = 1'b1; in_opcode = 7'h55;
        tick();
        foreach (dut_slot[i]) begin
            checks++;
            if (dut_slot[i] !== 7'h00) begin
                errors++; $display("FAIL reset_%s got %h want 00", slot_name[i], dut_slot[i]);
            end
        end
        checks++;
        if ({pipeline_state, empty, stall_err} !== 4'b0010) begin
            errors++; $display("FAIL reset_flags got state=%b empty=%b err=%b want 00/1/0",
                                pipeline_state, empty, stall_err);
        end
        checks++;
        if (retired !== 16'd0 || stall_cycles !== 16'd0) begin
            errors++; $display("FAIL reset_counters got ret=%0d stc=%0d want 0/0", retired, stall_cycles);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready got %b want 0", in_ready);
        end
        rst_n = 1'b1;
        idle_inputs();
    endtask

    task automatic test_stream();
        do_reset();
        in_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            in_opcode = 7'(k);
            tick();
        end
        checks++;
        if (wb !== 7'h01) begin
            errors++; $display("FAIL stream_wb_first got %h want 01", wb);
        end
        idle_inputs();
        repeat (5) tick();
        checks++;
        if (retired !== 16'd5) begin
            errors++; $display("FAIL stream_retired got %0d want 5", retired);
        end
        checks++;
        if (empty !== 1'b1) begin
            errors++; $display("FAIL stream_empty got %b want 1", empty);
        end
    endtask

    task automatic test_load_stall();
        do_reset();
        in_valid = 1'b1; in_opcode = 7'h03; tick();
        in_opcode = 7'h33; tick();
        checks++;
        if (pipeline_state !== 2'b01) begin
            errors++; $display("FAIL ld_state_decode got %b want 01", pipeline_state);
        end
        in_valid = 1'b0; tick();
        checks++;
        if (decode !== 7'h33 || pipeline_state !== 2'b10) begin
            errors++; $display("FAIL ld_pre_stall got dec=%h state=%b want 33/10", decode, pipeline_state);
        end
        stall = 1'b1; tick();
        stall = 1'b0;
        checks++;
        if (exec !== 7'h00 || decode !== 7'h33 || mem !== 7'h03) begin
            errors++; $display("FAIL ld_stall_slots got ex=%h dec=%h mem=%h want 00/33/03", exec, decode, mem);
        end
        checks++;
        if (pipeline_state !== 2'b11) begin
            errors++; $display("FAIL ld_state_mem got %b want 11", pipeline_state);
        end
        checks++;
        if (stall_cycles !== 16'd1) begin
            errors++; $display("FAIL ld_stall_cycles got %0d want 1", stall_cycles);
        end
        tick();
        checks++;
        if (exec !== 7'h33) begin
            errors++; $display("FAIL ld_resume_exec got %h want 33", exec);
        end
    endtask

    task automatic test_flush_stall();
        do_reset();
        in_valid = 1'b1;
        in_opcode = 7'h13; tick();
        in_opcode = 7'h21; tick();
        in_opcode = 7'h22; tick();
        stall = 1'b1; flush = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL fl_in_ready got %b want 0", in_ready);
        end
        tick();
        idle_inputs();
        checks++;
        if ({fetch, decode, exec} !== 21'd0 || mem !== 7'h13) begin
            errors++; $display("FAIL fl_slots got f=%h d=%h e=%h m=%h want 00/00/00/13", fetch, decode, exec, mem);
        end
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL fl_in_ready_idle got %b want 1", in_ready);
        end
    endtask

    task automatic test_stall_err();
        do_reset();
        stall = 1'b1;
        repeat (7) tick();
        checks++;
        if (stall_err !== 1'b0) begin
            errors++; $display("FAIL serr_early got %b want 0", stall_err);
        end
        tick();
        checks++;
        if (stall_err !== 1'b1) begin
            errors++; $display("FAIL serr_8th got %b want 1", stall_err);
        end
        stall = 1'b0;
        repeat (3) tick();
        checks++;
        if (stall_err !== 1'b1 || stall_cycles !== 16'd8) begin
            errors++; $display("FAIL serr_sticky got err=%b stc=%0d want 1/8", stall_err, stall_cycles);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        stall = 1'b1; repeat (8) tick();
        stall = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_opcode = 7'h40 + 7'(k); tick();
        end
        rst_n = 1'b0; stall = 1'b1; flush = 1'b1;
        tick();
        rst_n = 1'b1; idle_inputs();
        checks++;
        if ({fetch, decode, exec, mem, wb} !== 35'd0 || pipeline_state !== 2'b00 || empty !== 1'b1) begin
            errors++; $display("FAIL rst_mid_slots got f=%h d=%h e=%h m=%h w=%h st=%b e=%b want all 0/00/1",
                                fetch, decode, exec, mem, wb, pipeline_state, empty);
        end
        checks++;
        if (retired !== 16'd0 || stall_cycles !== 16'd0 || stall_err !== 1'b0) begin
            errors++; $display("FAIL rst_mid_counters got ret=%0d stc=%0d err=%b want 0/0/0",
                                retired, stall_cycles, stall_err);
        end
    endtask

    task automatic test_bubbles();
        do_reset();
        in_valid = 1'b1; in_opcode = 7'h2A; tick();
        idle_inputs();
        repeat (4) tick();
        checks++;
        if (wb !== 7'h2A || empty !== 1'b0 || {fetch, decode, exec, mem} !== 28'd0) begin
            errors++; $display("FAIL bub_in_wb got wb=%h empty=%b want 2a/0", wb, empty);
        end
        tick();
        checks++;
        if (empty !== 1'b1 || retired !== 16'd1) begin
            errors++; $display("FAIL bub_drained got empty=%b ret=%0d want 1/1", empty, retired);
        end
        tick();
    endtask

    task automatic test_random();
        int burst = 0;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_opcode = ($urandom_range(0, 3) == 0) ? 7'h03 : 7'($urandom);
            if (burst == 0 && $urandom_range(0, 29) == 0) burst = $urandom_range(6, 11);
            stall = (burst > 0) || ($urandom_range(0, 4) == 0);
            if (burst > 0) burst--;
            flush = ($urandom_range(0, 9) == 0);
            #1;
            checks++;
            if (in_ready !== (!stall && !flush)) begin
                errors++; $display("FAIL rnd_in_ready n=%0d got %b want %b", n, in_ready, !stall && !flush);
            end
            tick();
            foreach (dut_slot[i]) begin
                checks++;
                if (dut_slot[i] !== m_slot[i]) begin
                    errors++; $display("FAIL rnd_%s n=%0d got %h want %h", slot_name[i], n, dut_slot[i], m_slot[i]);
                end
            end
            checks++;
            if (pipeline_state !== exp_state() || empty !== exp_empty()) begin
                errors++; $display("FAIL rnd_state n=%0d got st=%b em=%b want %b/%b",
                                    n, pipeline_state, empty, exp_state(), exp_empty());
            end
            checks++;
            if (retired !== m_ret || stall_cycles !== m_stc || stall_err !== m_err) begin
                errors++; $display("FAIL rnd_counters n=%0d got ret=%0d stc=%0d err=%b want %0d/%0d/%b",
                                    n, retired, stall_cycles, stall_err, m_ret, m_stc, m_err);
            end
        end
        idle_inputs();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        foreach (m_slot[i]) m_slot[i] = 7'h00;
        m_ret = 0; m_stc = 0; m_run = 0; m_err = 1'b0;
        #2;
        test_reset();
        test_stream();
        test_load_stall();
        test_flush_stall();
        test_stall_err();
        test_reset_midflight();
        test_bubbles();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_opcode_tracker.md
# pipe_opcode_tracker

Tracks the 7-bit opcode in each of the fetch/decode/exec/mem/writeback slots of the 5-stage pipeline and advances them every cycle. Acts on the hazard unit's `stall` by freezing fetch/decode and injecting a bubble into exec. Acts on `flush` by squashing the younger slots. It is the upstream producer of the `fetch`, `decode`, `exec`, `mem` and `pipeline_state` buses that the hazard unit consumes, and the consumer of its `stall` output.

## Interface
- `OPW`, 7, opcode width
- `BUBBLE`, 7'b0000000, opcode inserted for empty/squashed slots
- `LOAD_OP`, 7'b0000011, opcode classed as a load for `pipeline_state`
- `STALL_MAX`, 8, consecutive stall cycles tolerated before `stall_err`
- `clk` in 1: rising-edge clock
- `rst_n` in 1: synchronous, active-low reset
- `in_valid` in 1: `in_opcode` is offered by the instruction source
- `in_opcode` in OPW: opcode to enter fetch
- `in_ready` out 1: combinational, equals `!stall && !flush`; an opcode transfers when `in_valid && in_ready`
- `stall` in 1: from hazard unit; hold fetch/decode, bubble exec
- `flush` in 1: branch redirect; squash fetch/decode/exec
- `fetch`, `decode`, `exec`, `mem`, `wb` out OPW each: registered slot opcodes
- `pipeline_state` out 2: registered; 00 no load in decode/exec/mem, 01 load in decode, 10 load in exec, 11 load in mem; priority decode > exec > mem (youngest wins)
- `empty` out 1: registered; all five slots equal `BUBBLE`
- `retired` out 16: count of non-bubble opcodes leaving `wb`, saturating at 16'hFFFF
- `stall_cycles` out 16: count of cycles with `stall` high, saturating
- `stall_err` out 1: sticky; set when `stall` has been high for `STALL_MAX` consecutive cycles

## Operation
- Reset (`rst_n`=0 at a clk edge): all slots = `BUBBLE`, `pipeline_state`=00, `empty`=1, both counters 0, `stall_err`=0, stall-run counter 0. Reset overrides `flush` and `stall`, and abandons any in-flight state mid-operation.
- Per-edge update, in priority order:
  - `flush`: `fetch`, `decode` and `exec` take `BUBBLE`; `mem` takes the old `exec`; `wb` takes the old `mem`. `flush` wins over a simultaneous `stall`.
  - `stall`: `fetch` and `decode` hold; `exec` takes `BUBBLE`; `mem` takes the old `exec`; `wb` takes the old `mem`.
  - Otherwise: `fetch` takes `in_valid ? in_opcode : BUBBLE`; `decode` takes the old `fetch`; `exec` takes the old `decode`; `mem` takes the old `exec`; `wb` takes the old `mem`.
- `retired` increments when the old `wb` is not `BUBBLE`, on every non-reset edge regardless of stall or flush.
- `pipeline_state` and `empty` are computed from the next-state slot values. They are therefore coherent with the slot outputs on the same cycle.
- Stall-run counter:
  - Increments while `stall` is high; clears when `stall` is low.
  - Saturates at `STALL_MAX`.
  - `stall_err` sets on the edge where the counter reaches `STALL_MAX`, and holds until reset.

## Timing
- Opcode latency: accepted at edge N, appears on `fetch` after N, `decode` after N+1, `exec` after N+2, `mem` after N+3, `wb` after N+4. Each stall cycle adds one cycle for opcodes still in fetch/decode.
- `in_ready` is purely combinational from `stall`/`flush`. No opcode is consumed while it is low, so the source must hold `in_opcode` stable.
- All outputs except `in_ready` are registered, with zero combinational paths from inputs.
- Saturation: counters stick at 16'hFFFF and never wrap.
- `stall` driven from the hazard unit combinationally from these registered slot outputs is legal; no loop exists.

## Test plan
- Reset, then stream opcodes 0x01..0x05 with `in_valid`=1 → `wb` = 0x01 five edges after the first accept; `retired` = 5 after the last one drains; `empty`=1 afterwards.
- Drive `in_opcode` 0x03 then 0x33, and raise `stall` for one cycle when 0x33 is in `decode` → `exec` = 0x00 for one cycle; `decode` holds 0x33; `pipeline_state` reads 10 then 11 as the load advances; `stall_cycles` = 1.
- Assert `stall` and `flush` together with 0x13 in `exec` → `fetch`/`decode`/`exec` = 0x00; `mem` = 0x13; `in_ready` = 0.
- Hold `stall` high for 8 cycles → `stall_err` rises on the 8th edge and stays high after `stall` drops; `stall_cycles` = 8.
- Pulse `rst_n` low with the pipe full and `stall_err` set → next cycle all slots 0x00, `pipeline_state`=00, `empty`=1, counters 0, `stall_err`=0.
- Hold `in_valid` low for 6 cycles after a single opcode → bubbles fill behind it; `empty` rises when the opcode leaves `wb`.
